// File: rtl/mux7_rr_sel_scheduler_pkg.sv
// Shared definitions for the 7:1 channel-mux select scheduler.
package mux7_pkg;

    localparam int N_CH  = 7;
    localparam int SEL_W = 3;

    // Channel G; the round-robin pointer sits here after reset so the first
    // search begins at channel A.
    localparam logic [SEL_W-1:0] LAST_CH = 3'd6;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Next channel index with wrap 6 -> 0; never produces the unused code 7.
    function automatic logic [SEL_W-1:0] inc_mod7(input logic [SEL_W-1:0] x);
        if (x >= LAST_CH) begin
            return '0;
        end
        return x + 3'd1;
    endfunction

endpackage

// File: rtl/mux7_rr_sel_scheduler_rr_pick7.sv
// Combinational round-robin search over seven request lines.
// Scans last+1, last+2, ... mod 7, so 'last' itself is examined last and a
// lone requester can win again. With mask_en set, the channel at 'last' is
// removed from the search (used when releasing the current grant).
module rr_pick7
    import mux7_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] last,
    input  logic             mask_en,
    output logic [SEL_W-1:0] next,
    output logic             any
);

    logic [N_CH-1:0]  req_m;
    logic [SEL_W-1:0] idx;

    // Drop the excluded channel from the request vector.
    always_comb begin
        req_m = req;
        for (int i = 0; i < N_CH; i++) begin
            if (mask_en && (last == SEL_W'(i))) begin
                req_m[i] = 1'b0;
            end
        end
    end

    // First requesting channel after 'last', wrapping through G back to A.
    always_comb begin
        next = '0;
        any  = 1'b0;
        idx  = inc_mod7(last);
        for (int k = 0; k < N_CH; k++) begin
            if (!any && req_m[idx]) begin
                next = idx;
                any  = 1'b1;
            end
            idx = inc_mod7(idx);
        end
    end

endmodule

// File: rtl/mux7_rr_sel_scheduler.sv
// Round-robin grant scheduler driving the select of the 7:1 channel mux.
// Each grant is held for at least DWELL cycles and until the consumer acks;
// releases with other requesters pending hand over without a bubble.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no grant; valid low; waiting for any request
//   GRANT | Sel holds a granted channel; dwell counting down to 0,
//         | release on ack once dwell is done, cancel if req[Sel] drops
module mux7_rr_sel_scheduler
    import mux7_pkg::*;
#(
    parameter int DWELL = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    input  logic             ack,
    output logic [SEL_W-1:0] Sel,
    output logic             valid,
    output logic [CNT_W-1:0] grant_cnt
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DW_RELOAD = DW_W'(DWELL - 1);

    state_t           state;
    logic [SEL_W-1:0] last;
    logic [DW_W-1:0]  dwell;

    logic [SEL_W-1:0] pick_last;
    logic             pick_mask;
    logic [SEL_W-1:0] next;
    logic             any;
    logic             dwell_done;
    logic             release_ok;
    logic             cancel;

    // While granted, search relative to the current channel and exclude it;
    // while idle, search from the last served/cancelled channel, unmasked.
    always_comb begin
        pick_last = last;
        pick_mask = 1'b0;
        if (state == GRANT) begin
            pick_last = Sel;
            pick_mask = 1'b1;
        end
    end

    rr_pick7 u_pick (
        .req     (req),
        .last    (pick_last),
        .mask_en (pick_mask),
        .next    (next),
        .any     (any)
    );

    assign dwell_done = (dwell == '0);
    // Ack beats a simultaneous cancel only once the dwell has expired.
    assign release_ok = (state == GRANT) && ack && dwell_done;
    assign cancel     = (state == GRANT) && !release_ok && !req[Sel];

    // Grant FSM with registered Sel/valid, dwell timer, pointer and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            Sel       <= '0;
            valid     <= 1'b0;
            grant_cnt <= '0;
            last      <= LAST_CH;
            dwell     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    if (any) begin
                        Sel   <= next;
                        valid <= 1'b1;
                        dwell <= DW_RELOAD;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_ok) begin
                        last      <= Sel;
                        grant_cnt <= grant_cnt + CNT_W'(1);
                        if (any) begin
                            Sel   <= next;
                            valid <= 1'b1;
                            dwell <= DW_RELOAD;
                        end else begin
                            valid <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (cancel) begin
                        last  <= Sel;
                        valid <= 1'b0;
                        state <= IDLE;
                    end else if (!dwell_done) begin
                        dwell <= dwell - DW_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux7_rr_sel_scheduler.sv
// Directed bench for the round-robin mux select scheduler.
module tb_mux7_rr_sel_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] req = 7'h00;
    logic       ack = 1'b0;
    logic [2:0] sel;
    logic       valid;
    logic [7:0] cnt;

    logic [6:0] req3 = 7'h00;
    logic       ack3 = 1'b0;
    logic [2:0] sel3;
    logic       valid3;
    logic [7:0] cnt3;

    logic [6:0] req1 = 7'h00;
    logic       ack1 = 1'b0;
    logic [2:0] sel1;
    logic       valid1;
    logic [7:0] cnt1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux7_rr_sel_scheduler #(.DWELL(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .ack(ack),
        .Sel(sel), .valid(valid), .grant_cnt(cnt)
    );

    mux7_rr_sel_scheduler #(.DWELL(3), .CNT_W(8)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .ack(ack3),
        .Sel(sel3), .valid(valid3), .grant_cnt(cnt3)
    );

    mux7_rr_sel_scheduler #(.DWELL(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .ack(ack1),
        .Sel(sel1), .valid(valid1), .grant_cnt(cnt1)
    );

    typedef struct {
        logic       rst;
        logic [6:0] req;
        logic       ack;
        logic       sel_care;
        logic [2:0] sel;
        logic       vld;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [6:0] q, input logic a,
                                input logic sc, input logic [2:0] s,
                                input logic v, input logic [7:0] c);
        vec_t t;
        t.rst = r; t.req = q; t.ack = a; t.sel_care = sc;
        t.sel = s; t.vld = v; t.cnt = c;
        return t;
    endfunction

    initial begin
        string nm;
        int    range_bad;
        int    vld_drop;

        // reset held with all requests, then first grant to A
        tbl.push_back(mk(1, 7'h7F, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 7'h7F, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 7'h7F, 0, 1, 0, 1, 0));
        // all requesting, ack held: each channel held two cycles, 0,0,1,1,..,6,6,0
        for (int e = 1; e <= 14; e++) begin
            tbl.push_back(mk(0, 7'h7F, 1, 1, 3'((e / 2) % 7), 1, 8'(e / 2)));
        end
        // only A and G requesting: alternate 0 and 6
        tbl.push_back(mk(1, 7'b1000001, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 7'b1000001, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 7'b1000001, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 7'b1000001, 1, 1, 6, 1, 1));
        tbl.push_back(mk(0, 7'b1000001, 1, 1, 6, 1, 1));
        tbl.push_back(mk(0, 7'b1000001, 1, 1, 0, 1, 2));
        tbl.push_back(mk(0, 7'b1000001, 1, 1, 0, 1, 2));
        tbl.push_back(mk(0, 7'b1000001, 1, 1, 6, 1, 3));
        // grant C, other requests toggle, then C drops: next is E
        tbl.push_back(mk(1, 7'b0000000, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 7'b0000100, 0, 1, 2, 1, 0));
        tbl.push_back(mk(0, 7'b1010101, 0, 1, 2, 1, 0));
        tbl.push_back(mk(0, 7'b1010001, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 7'b1010001, 0, 1, 4, 1, 0));
        // grant C, cancel with only A,B pending: search wraps to A
        tbl.push_back(mk(1, 7'b0000000, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 7'b0000100, 0, 1, 2, 1, 0));
        tbl.push_back(mk(0, 7'b0000011, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 7'b0000011, 0, 1, 0, 1, 0));
        // cancel+ack before dwell done -> cancel; after dwell done -> release
        tbl.push_back(mk(1, 7'b0000000, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 7'b0000100, 0, 1, 2, 1, 0));
        tbl.push_back(mk(0, 7'b0001000, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 7'b0001000, 0, 1, 3, 1, 0));
        tbl.push_back(mk(0, 7'b0001000, 0, 1, 3, 1, 0));
        tbl.push_back(mk(0, 7'b0100000, 1, 1, 5, 1, 1));
        tbl.push_back(mk(0, 7'b0000000, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 7'b0000000, 0, 0, 0, 0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst;
            req = tbl[i].req;
            ack = tbl[i].ack;
            tick();
            if (tbl[i].sel_care) begin
                nm = $sformatf("row%0d_sel", i);
                chk(nm, int'(sel), int'(tbl[i].sel));
            end
            nm = $sformatf("row%0d_valid", i);
            chk(nm, int'(valid), int'(tbl[i].vld));
            nm = $sformatf("row%0d_cnt", i);
            chk(nm, int'(cnt), int'(tbl[i].cnt));
        end

        // DWELL=3: ack in first granted cycle ignored, ack in third releases
        rst = 0; req3 = 7'b0000001; ack3 = 0;
        tick();
        chk("d3_grant_sel", int'(sel3), 0);
        chk("d3_grant_valid", int'(valid3), 1);
        ack3 = 1;
        tick();
        chk("d3_early_ack_valid", int'(valid3), 1);
        chk("d3_early_ack_cnt", int'(cnt3), 0);
        ack3 = 0;
        tick();
        chk("d3_wait_valid", int'(valid3), 1);
        ack3 = 1;
        tick();
        chk("d3_release_valid", int'(valid3), 0);
        chk("d3_release_cnt", int'(cnt3), 1);
        ack3 = 0; req3 = 7'h00;

        // DWELL=1: ack in the first granted cycle releases at once
        req1 = 7'b0000010; ack1 = 0;
        tick();
        chk("d1_grant_sel", int'(sel1), 1);
        ack1 = 1;
        tick();
        chk("d1_release_valid", int'(valid1), 0);
        chk("d1_release_cnt", int'(cnt1), 1);
        ack1 = 0; req1 = 7'h00;

        // mid-grant reset: pointer moved to D, grant E, reset, search restarts at A
        rst = 1; req = 7'h00; ack = 0;
        tick();
        rst = 0; req = 7'b0001000; ack = 1;
        tick(); tick(); tick();
        chk("pre_rst_idle_valid", int'(valid), 0);
        req = 7'b0010000; ack = 0;
        tick();
        chk("pre_rst_sel", int'(sel), 4);
        chk("pre_rst_valid", int'(valid), 1);
        rst = 1;
        tick();
        chk("mid_rst_sel", int'(sel), 0);
        chk("mid_rst_valid", int'(valid), 0);
        chk("mid_rst_cnt", int'(cnt), 0);
        rst = 0; req = 7'h7F;
        tick();
        chk("post_rst_sel", int'(sel), 0);
        chk("post_rst_valid", int'(valid), 1);

        // counter wrap: 256 releases bring grant_cnt from 0 back to 0
        ack = 1;
        range_bad = 0;
        vld_drop  = 0;
        for (int e = 1; e <= 510; e++) begin
            tick();
            if (sel > 3'd6) range_bad++;
            if (!valid) vld_drop++;
        end
        chk("wrap_cnt_ff", int'(cnt), 255);
        tick(); tick();
        chk("wrap_cnt_00", int'(cnt), 0);
        chk("wrap_sel_range", range_bad, 0);
        chk("wrap_valid_held", vld_drop, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
